int_ctrl: RTL and testbench



---
 rtl/int_ctrl.sv | 141 ++++++++++++++
 tb/tb_int_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects sources into pending bits, arbitrates by fixed
// priority (lowest index wins) and runs one req/ack/complete cycle at a time.
module int_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               int_req_o,
  output logic [ID_W-1:0]    int_id_o,
  input  logic               int_ack_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q, src_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic               int_req_q, int_req_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] id_onehot;
  logic [ID_W-1:0]    win_id;
  logic               wr_enable, wr_pending, wr_complete;
  logic               sel_en, sel_pend;
  logic               in_service;
  logic               unused_ok;

  assign unused_ok = ^{addr_i[31:4], wdata_i[31:NUM_SRC]};

  assign int_req_o  = int_req_q;
  assign int_id_o   = int_id_q;
  assign in_service = (state_q == SERVICE);

  always_comb begin
    rise        = src_i & ~src_q;
    active      = pending_q & enable_q;
    wr_enable   = we_i && (addr_i[3:0] == 4'h0);
    wr_pending  = we_i && (addr_i[3:0] == 4'h4);
    wr_complete = we_i && (addr_i[3:0] == 4'h8);

    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int_id_q == ID_W'(i)) id_onehot[i] = 1'b1;
    end
    sel_en   = |(enable_q & id_onehot);
    sel_pend = |(pending_q & id_onehot);

    // Scan from the top so the lowest set index is the one left standing.
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_i;
    enable_d  = enable_q;
    pending_d = pending_q;
    int_req_d = int_req_q;
    int_id_d  = int_id_q;

    if (wr_enable)  enable_d  = wdata_i[NUM_SRC-1:0];
    if (wr_pending) pending_d = pending_d & ~wdata_i[NUM_SRC-1:0];

    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d   = REQ;
          int_req_d = 1'b1;
          int_id_d  = win_id;
        end
      end
      REQ: begin
        if (int_ack_i) begin
          state_d   = SERVICE;
          int_req_d = 1'b0;
          pending_d = pending_d & ~id_onehot;
        end else if (!sel_en || !sel_pend) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end
      end
      SERVICE: begin
        if (wr_complete && (wdata_i[ID_W-1:0] == int_id_q)) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        int_req_d = 1'b0;
      end
    endcase

    // A fresh edge outranks any clear landing in the same cycle.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i[3:0])
      4'h0: rdata_o = 32'(enable_q);
      4'h4: rdata_o = 32'(pending_q);
      4'h8: begin
        rdata_o     = 32'(int_id_q);
        rdata_o[31] = in_service;
      end
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with a queue of expected interrupt IDs
// that is filled as sources are driven and drained as requests appear.
module tb_int_ctrl;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 4;

  logic               clk;
  logic               rst_n;
  logic               we_i;
  logic [31:0]        addr_i;
  logic [31:0]        wdata_i;
  logic [31:0]        rdata_o;
  logic [NUM_SRC-1:0] src_i;
  logic               int_req_o;
  logic [ID_W-1:0]    int_id_o;
  logic               int_ack_i;

  logic [ID_W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  int_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .src_i     (src_i),
    .int_req_o (int_req_o),
    .int_id_o  (int_id_o),
    .int_ack_i (int_ack_i)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    addr_i  = {28'(($urandom_range(0, 1) != 0) ? 28'h123 : 28'h0), a};
    wdata_i = d;
    tick();
    we_i    = 1'b0;
    wdata_i = 32'($urandom);
  endtask

  task automatic reg_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr_i = {28'h0, a};
    #1;
    check(tag, rdata_o, exp);
  endtask

  task automatic ack();
    int_ack_i = 1'b1;
    tick();
    int_ack_i = 1'b0;
  endtask

  // Scoreboard: wait for a request, then pop the oldest expected ID.
  task automatic wait_req(input string tag);
    int waited;
    logic [ID_W-1:0] exp_id;
    waited = 0;
    while (!int_req_o && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_seen"}, 32'(int_req_o), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp_id = exp_q.pop_front();
      check({tag, "_id"}, 32'(int_id_o), 32'(exp_id));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    we_i      = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;
    src_i     = '0;
    int_ack_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_req", 32'(int_req_o), 32'd0);
    check("rst_id", 32'(int_id_o), 32'd0);
    reg_check("rst_enable", 4'h0, 32'h0);
    reg_check("rst_pending", 4'h4, 32'h0);
    reg_check("rst_complete", 4'h8, 32'h0);

    // Timer pulse with exact latency; ack clears pending; complete returns to idle
    reg_write(4'h0, 32'hFFFF_FF01);
    reg_check("en_mask", 4'h0, 32'h1);
    src_i = 8'h01;
    exp_q.push_back(4'd0);
    tick();
    src_i = 8'h00;
    reg_check("t1_pend", 4'h4, 32'h1);
    check("t1_req_early", 32'(int_req_o), 32'd0);
    tick();
    check("t1_req", 32'(int_req_o), 32'd1);
    wait_req("t1");
    tick();
    ack();
    check("t1_req_ack", 32'(int_req_o), 32'd0);
    reg_check("t1_pend_ack", 4'h4, 32'h0);
    reg_check("t1_insvc", 4'h8, 32'h8000_0000);
    reg_write(4'hC, 32'hFFFF_FFFF);
    reg_check("t1_c_ignored", 4'h0, 32'h1);
    reg_write(4'h8, 32'h0);
    reg_check("t1_idle", 4'h8, 32'h0);

    // Simultaneous rises on 5 and 2: 2 first, 5 two cycles after its complete
    reg_write(4'h0, 32'hFF);
    src_i = 8'h24;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd5);
    tick();
    src_i = 8'h00;
    wait_req("t2a");
    ack();
    reg_check("t2_pend", 4'h4, 32'h20);
    reg_write(4'h8, 32'h2);
    check("t2_req_gap", 32'(int_req_o), 32'd0);
    tick();
    check("t2_req_next", 32'(int_req_o), 32'd1);
    wait_req("t2b");
    ack();
    reg_write(4'h8, 32'h5);

    // Mismatched complete keeps service; matching one releases it
    src_i = 8'h08;
    exp_q.push_back(4'd3);
    tick();
    src_i = 8'h00;
    wait_req("t3");
    ack();
    reg_write(4'h8, 32'h4);
    reg_check("t3_bad_cmpl", 4'h8, 32'h8000_0003);
    reg_write(4'h8, 32'h3);
    reg_check("t3_good_cmpl", 4'h8, 32'h0000_0003);
    check("t3_no_req", 32'(int_req_o), 32'd0);

    // Withdrawal by disabling during a request, then re-enable
    src_i = 8'h02;
    exp_q.push_back(4'd1);
    tick();
    src_i = 8'h00;
    wait_req("t4a");
    reg_write(4'h0, 32'h0);
    tick();
    check("t4_withdrawn", 32'(int_req_o), 32'd0);
    reg_check("t4_pend_kept", 4'h4, 32'h2);
    exp_q.push_back(4'd1);
    reg_write(4'h0, 32'hFF);
    wait_req("t4b");
    ack();
    reg_write(4'h8, 32'h1);

    // Rise beats a same-cycle write-1-to-clear (sources disabled)
    reg_write(4'h0, 32'h0);
    src_i = 8'h10;
    reg_write(4'h4, 32'h10);
    src_i = 8'h00;
    reg_check("t5_rise_wins", 4'h4, 32'h10);
    reg_write(4'h4, 32'h10);
    reg_check("t5_w1c", 4'h4, 32'h0);
    reg_write(4'h0, 32'hFF);

    // Held level gives one request; re-edge during service is kept
    src_i = 8'h01;
    exp_q.push_back(4'd0);
    wait_req("t6a");
    ack();
    repeat (4) tick();
    reg_check("t6_held_once", 4'h4, 32'h0);
    check("t6_no_rereq", 32'(int_req_o), 32'd0);
    src_i = 8'h00;
    tick();
    src_i = 8'h01;
    tick();
    reg_check("t6_reedge", 4'h4, 32'h1);
    exp_q.push_back(4'd0);
    reg_write(4'h8, 32'h0);
    wait_req("t6b");
    ack();
    reg_write(4'h8, 32'h0);

    // Reset in the middle of a request; held source needs ENABLE rewritten
    src_i = 8'h03;
    exp_q.push_back(4'd1);
    wait_req("t7a");
    rst_n = 1'b0;
    tick();
    check("t7_rst_req", 32'(int_req_o), 32'd0);
    check("t7_rst_id", 32'(int_id_o), 32'd0);
    reg_check("t7_rst_en", 4'h0, 32'h0);
    reg_check("t7_rst_pend", 4'h4, 32'h0);
    rst_n = 1'b1;
    tick();
    reg_check("t7_post_pend", 4'h4, 32'h3);
    repeat (3) tick();
    check("t7_no_req", 32'(int_req_o), 32'd0);
    exp_q.push_back(4'd0);
    reg_write(4'h0, 32'h1);
    wait_req("t7b");
    ack();
    reg_write(4'h8, 32'h0);
    src_i = 8'h00;

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
